// File: rtl/gcd_operand_sequencer.sv
// -----------------------------------------------------------------------------
// gcd_operand_sequencer
//
// Builds two 16-bit operands from a 4-bit MSB-first nibble stream, launches
// the external subtractive GCD core with a one-cycle load pulse, waits for the
// core's valid flag, then returns the 16-bit result as four MSB-first nibbles
// under a valid/ready handshake.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         operand nibble (A first, then B, each MSB-first)
//   din_valid   din qualifier
//   din_ready   nibble accepted this cycle (only while collecting)
//   gcd_value1  operand A to the core
//   gcd_value2  operand B to the core
//   gcd_load    single-cycle load strobe to the core
//   gcd_result  result from the core
//   gcd_valid   result-valid flag from the core (honoured only while waiting)
//   res_nibble  result nibble, MSB-first
//   res_valid   res_nibble qualifier
//   res_ready   consumer accepts res_nibble
//   busy        operation in progress (start, wait or send)
// -----------------------------------------------------------------------------
module gcd_operand_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] gcd_value1,
    output logic [15:0] gcd_value2,
    output logic        gcd_load,
    input  logic [15:0] gcd_result,
    input  logic        gcd_valid,
    output logic [3:0]  res_nibble,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_SEND    = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [1:0]  send_cnt_reg, send_cnt_next;
    logic [15:0] a_reg, a_next;
    logic [15:0] b_reg, b_next;
    logic [15:0] result_reg, result_next;

    logic        nib_accept;
    logic        res_accept;
    logic [15:0] b_shifted;
    logic [3:0]  result_nibbles [4];

    // Result split into nibbles, index 0 being the most significant one.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_res_nib
            assign result_nibbles[gi] = result_reg[15-4*gi -: 4];
        end
    endgenerate

    assign din_ready  = (state_reg == ST_COLLECT);
    assign busy       = ~din_ready;
    assign gcd_load   = (state_reg == ST_START);
    assign res_valid  = (state_reg == ST_SEND);
    assign res_nibble = res_valid ? result_nibbles[send_cnt_reg] : 4'd0;
    assign gcd_value1 = a_reg;
    assign gcd_value2 = b_reg;

    assign nib_accept = din_ready & din_valid;
    assign res_accept = res_valid & res_ready;

    // B as it will look once the current nibble is shifted in; needed to
    // decide the zero-operand bypass on the same edge as the 8th nibble.
    assign b_shifted  = {b_reg[11:0], din};

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        send_cnt_next = send_cnt_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        result_next   = result_reg;

        case (state_reg)
            ST_COLLECT: begin
                if (nib_accept) begin
                    // cnt wraps 7 -> 0, so it is already cleared for the next run
                    cnt_next = cnt_reg + 3'd1;
                    if (!cnt_reg[2]) begin
                        a_next = {a_reg[11:0], din};
                    end else begin
                        b_next = b_shifted;
                    end
                    if (cnt_reg == 3'd7) begin
                        if ((a_reg != 16'd0) && (b_shifted != 16'd0)) begin
                            state_next = ST_START;
                        end else begin
                            // The subtractive core never terminates on a zero
                            // operand; gcd(0,x) = x, gcd(0,0) = 0 is just A|B.
                            state_next    = ST_SEND;
                            result_next   = a_reg | b_shifted;
                            send_cnt_next = 2'd0;
                        end
                    end
                end
            end
            ST_START: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (gcd_valid) begin
                    result_next   = gcd_result;
                    send_cnt_next = 2'd0;
                    state_next    = ST_SEND;
                end
            end
            default: begin // ST_SEND
                if (res_accept) begin
                    send_cnt_next = send_cnt_reg + 2'd1;
                    if (send_cnt_reg == 2'd3) begin
                        state_next = ST_COLLECT;
                        cnt_next   = 3'd0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_COLLECT;
            cnt_reg      <= 3'd0;
            send_cnt_reg <= 2'd0;
            a_reg        <= 16'd0;
            b_reg        <= 16'd0;
            result_reg   <= 16'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            send_cnt_reg <= send_cnt_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            result_reg   <= result_next;
        end
    end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gcd_operand_sequencer
//
// Drives operand nibbles into gcd_operand_sequencer with a simple GCD core
// stand-in attached, and compares the returned nibbles, load pulses and
// latencies against a reference computed from the operands alone.
// -----------------------------------------------------------------------------
module tb_gcd_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  din = 4'd0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] gcd_value1;
    logic [15:0] gcd_value2;
    logic        gcd_load;
    logic [15:0] gcd_result;
    logic        gcd_valid;
    logic [3:0]  res_nibble;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gcd_operand_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .gcd_value1 (gcd_value1),
        .gcd_value2 (gcd_value2),
        .gcd_load   (gcd_load),
        .gcd_result (gcd_result),
        .gcd_valid  (gcd_valid),
        .res_nibble (res_nibble),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    // ---------------- GCD core stand-in ----------------
    // Subtractive GCD, result presented core_lat cycles after the load edge.
    // Valid stays high until the next load (stale valid), and the core is not
    // reset by rst_n. junk_valid injects a bogus valid/result pair.
    logic [15:0] core_res = 16'd0;
    logic        core_valid = 1'b0;
    int          core_cnt = 0;
    int          core_lat = 4;
    logic        junk_valid = 1'b0;

    function automatic logic [15:0] sub_gcd(input logic [15:0] x, input logic [15:0] y);
        while (x != 16'd0 && y != 16'd0) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return x | y;
    endfunction

    always @(posedge clk) begin
        if (gcd_load) begin
            core_res   <= sub_gcd(gcd_value1, gcd_value2);
            core_cnt   <= core_lat;
            core_valid <= 1'b0;
        end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
        end else if (core_cnt == 1) begin
            core_cnt   <= 0;
            core_valid <= 1'b1;
        end
    end

    assign gcd_valid  = core_valid | junk_valid;
    assign gcd_result = junk_valid ? 16'hDEAD : core_res;

    // ---------------- reference ----------------
    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] t;
        if (a == 16'd0 || b == 16'd0) return a | b;
        while (b != 16'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " gcd_load"},   32'(gcd_load),   32'd0);
        check({tag, " res_valid"},  32'(res_valid),  32'd0);
        check({tag, " res_nibble"}, 32'(res_nibble), 32'd0);
        check({tag, " busy"},       32'(busy),       32'd0);
        check({tag, " din_ready"},  32'(din_ready),  32'd1);
        check({tag, " gcd_value1"}, 32'(gcd_value1), 32'd0);
        check({tag, " gcd_value2"}, 32'(gcd_value2), 32'd0);
    endtask

    // Asynchronous reset applied mid-cycle, checked before any clock edge.
    task automatic do_reset(input string tag);
        din_valid = 1'b0;
        res_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs({tag, " async"});
        @(posedge clk); #1;
        check_reset_outputs({tag, " held"});
        rst_n = 1'b1;
        $display("[TB] reset %s applied and released", tag);
    endtask

    // gap:     0 back-to-back, 1 every 3rd cycle, 2 random
    // rr_mode: 0 res_ready=1, 1 pattern 1,0,0,1,0,1,1, 2 random
    // abort:   0 none, 1 reset mid-WAIT, 2 reset mid-SEND after 2 handshakes
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int gap,
                          input int rr_mode, input bit noise, input bit junk,
                          input int abort, input int lat);
        logic [31:0] ops;
        logic [15:0] exp, got_res;
        logic [6:0]  pat7;
        logic [3:0]  prev_nib;
        logic        prev_stall;
        logic [3:0]  got[$];
        int idx, hs, first_res, acc_cyc, load_cyc, loads, last_hs, rcyc, bad_acc, hold_err;
        bit done;

        ops = {a, b};
        exp = ref_gcd(a, b);
        pat7 = 7'b1101001;
        core_lat = lat;
        idx = 0; hs = 0; first_res = -1; acc_cyc = -1; load_cyc = -1; loads = 0;
        last_hs = -1; rcyc = 0; bad_acc = 0; hold_err = 0;
        prev_stall = 1'b0; prev_nib = 4'd0; done = 1'b0;

        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (abort == 1 && load_cyc >= 0 && cyc == load_cyc + 3) begin
                check("pre-abort in WAIT busy", 32'(busy), 32'd1);
                check("pre-abort in WAIT res_valid", 32'(res_valid), 32'd0);
                junk_valid = 1'b0;
                do_reset("mid-WAIT");
                return;
            end
            if (abort == 2 && hs == 2) begin
                check("pre-abort in SEND res_valid", 32'(res_valid), 32'd1);
                junk_valid = 1'b0;
                do_reset("mid-SEND");
                return;
            end

            // drive inputs for the coming edge
            if (idx < 8) begin
                case (gap)
                    0:       din_valid = 1'b1;
                    1:       din_valid = (cyc % 3 == 2);
                    default: din_valid = 1'($urandom_range(0, 1));
                endcase
                din = ops[31-4*idx -: 4];
                junk_valid = junk;
            end else begin
                junk_valid = 1'b0;
                din_valid = (noise && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
                din = 4'($urandom);
            end
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = pat7[rcyc % 7];
                default: res_ready = 1'($urandom_range(0, 1));
            endcase

            // observe this cycle
            if (hs == 4) begin
                check("busy after last handshake", 32'(busy), 32'd0);
                check("din_ready after last handshake", 32'(din_ready), 32'd1);
                done = 1'b1;
            end else begin
                if (din_valid && din_ready) begin
                    if (idx < 8) begin
                        idx++;
                        if (idx == 8) acc_cyc = cyc;
                    end else begin
                        bad_acc++;
                    end
                end
                if (gcd_load) begin
                    loads++;
                    load_cyc = cyc;
                    check("gcd_value1 at load", 32'(gcd_value1), 32'(a));
                    check("gcd_value2 at load", 32'(gcd_value2), 32'(b));
                end
                if (prev_stall && (!res_valid || res_nibble !== prev_nib)) hold_err++;
                if (res_valid) begin
                    if (first_res < 0) first_res = cyc;
                    prev_stall = !res_ready;
                    prev_nib = res_nibble;
                    if (res_ready) begin
                        got.push_back(res_nibble);
                        hs++;
                        if (hs == 4) last_hs = cyc;
                    end
                    rcyc++;
                end else begin
                    prev_stall = 1'b0;
                end
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end

        din_valid = 1'b0;
        junk_valid = 1'b0;
        got_res = 16'd0;
        foreach (got[i]) got_res = {got_res[11:0], got[i]};
        $display("[TB] op a=%04h b=%04h gap=%0d rr=%0d -> result %04h (ref %04h)",
                 a, b, gap, rr_mode, got_res, exp);
        check("handshake count", 32'(hs), 32'd4);
        check("result nibbles", 32'(got_res), 32'(exp));
        check("load pulses", 32'(loads), (a != 16'd0 && b != 16'd0) ? 32'd1 : 32'd0);
        if (a != 16'd0 && b != 16'd0) begin
            check("load latency", 32'(load_cyc), 32'(acc_cyc + 1));
            check("result latency", 32'(first_res), 32'(load_cyc + 2 + lat));
        end else begin
            check("zero-path latency", 32'(first_res), 32'(acc_cyc + 1));
        end
        if (rr_mode == 0) check("send length", 32'(last_hs - first_res), 32'd3);
        check("held nibble changed while stalled", 32'(hold_err), 32'd0);
        check("nibbles accepted while busy", 32'(bad_acc), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        int m;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("power-on reset");
        rst_n = 1'b1;

        run_op(16'h000C, 16'h0012, 0, 0, 1'b0, 1'b0, 0, 10);   // gcd 6
        run_op(16'h0000, 16'h0015, 0, 0, 1'b0, 1'b0, 0, 5);    // bypass
        run_op(16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0, 0, 5);    // bypass, 0
        run_op(16'hFFFF, 16'h0001, 0, 0, 1'b1, 1'b0, 0, 300);  // long run, noisy din
        run_op(16'h0030, 16'h0048, 0, 1, 1'b0, 1'b0, 0, 7);    // stalled output
        run_op(16'h000C, 16'h0012, 1, 0, 1'b0, 1'b1, 0, 3);    // gapped input
        run_op(16'h0123, 16'h0456, 0, 0, 1'b0, 1'b0, 1, 200);  // reset mid-WAIT
        run_op(16'h0123, 16'h0456, 0, 0, 1'b0, 1'b0, 2, 4);    // reset mid-SEND
        run_op(16'h0007, 16'h0015, 0, 0, 1'b0, 1'b1, 0, 6);    // fresh run, gcd 7

        for (int k = 0; k < 8; k++) begin
            m  = $urandom_range(1, 50);
            ra = 16'($urandom_range(1, 60) * m);
            rb = 16'($urandom_range(1, 60) * m);
            if ($urandom_range(0, 4) == 0) ra = 16'd0;
            run_op(ra, rb, $urandom_range(0, 2), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                   $urandom_range(1, 20));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
